// File: rtl/direction_input_if.sv
// ============================================================================
// Module      : direction_input_if
// Description : Button/command bundle between board pins and direction_input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface direction_input_if;
  logic [3:0] btn;
  logic       enable;
  logic [3:0] direction;
  logic       chord;

  modport master (
    output btn,
    output enable,
    input  direction,
    input  chord
  );

  modport slave (
    input  btn,
    input  enable,
    output direction,
    output chord
  );
endinterface

`default_nettype wire

// File: rtl/direction_input.sv
// ============================================================================
// Module      : direction_input
// Description : Synchronise, debounce and edge-detect four pushbuttons into a
//               one-hot single-cycle direction pulse; flag multi-button chords.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module direction_input #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  direction_input_if.slave  bus
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } state_e;

  logic [3:0]       s1_d, s1_q;
  logic [3:0]       s2_d, s2_q;
  logic [3:0]       cand_d, cand_q;
  logic [3:0]       stable_d, stable_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  state_e           state_q;
  logic [3:0]       direction_q;
  logic             chord_q;
  logic             single_bit;

  // Shared debouncer: any change of the synchronised vector restarts the count,
  // and the count saturates so a long-held vector is re-confirmed every cycle.
  always_comb begin
    s1_d     = bus.btn;
    s2_d     = s1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign single_bit = ((stable_q & (stable_q - 4'd1)) == 4'd0);

  // enable is only looked at on the IDLE exit, so a pulse already committed
  // to FIRE is issued regardless of later enable changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      direction_q <= 4'd0;
      chord_q     <= 1'b0;
    end else begin
      direction_q <= 4'd0;
      chord_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (stable_q != 4'd0) begin
            if (!single_bit) begin
              chord_q <= 1'b1;
              state_q <= HOLD;
            end else if (bus.enable) begin
              state_q <= FIRE;
            end else begin
              state_q <= HOLD;
            end
          end
        end
        FIRE: begin
          direction_q <= stable_q;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (stable_q == 4'd0) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.direction = direction_q;
  assign bus.chord     = chord_q;

endmodule

`default_nettype wire
